tl_line_mst: RTL and testbench

TileLink-UH master that turns a single cache-line request into A-channel beats and collects the matching D-channel response. It sits directly upstream of the TL memory slave: its A outputs drive the slave's A inputs, and its D inputs take the slave's D outputs. Writes are sent as a PutFullData burst of 128-bit beats. Reads are sent as one Get, and the AccessAckData beats are streamed to the requester.

---
 rtl/tl_line_mst_if.sv | 55 +++++
 rtl/tl_line_mst.sv | 95 +++++++++
 tb/tb_tl_line_mst.sv | 326 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/tl_line_mst_if.sv
// rtl/tl_line_mst_if.sv - request/response and TileLink A/D bundle for tl_line_mst
// master is the line master's view; slave is the requester plus memory slave side.
interface tl_line_mst_if;
   logic         req_valid;
   logic         req_ready;
   logic         req_wr;
   logic [31:0]  req_addr;
   logic [7:0]   req_size;
   logic [127:0] wr_data;
   logic         wr_data_valid;
   logic         wr_data_ready;
   logic [127:0] rd_data;
   logic         rd_data_valid;
   logic         rd_data_ready;
   logic         rsp_valid;
   logic         rsp_err;
   logic [2:0]   a_opcode;
   logic [2:0]   a_param;
   logic [7:0]   a_size;
   logic [2:0]   a_source;
   logic [31:0]  a_address;
   logic [15:0]  a_mask;
   logic [127:0] a_data;
   logic         a_corrupt;
   logic         a_valid;
   logic         a_ready;
   logic [2:0]   d_opcode;
   logic [1:0]   d_param;
   logic [7:0]   d_size;
   logic [2:0]   d_source;
   logic [2:0]   d_sink;
   logic         d_denied;
   logic [127:0] d_data;
   logic         d_corrupt;
   logic         d_valid;
   logic         d_ready;

   modport master (
      input  req_valid, req_wr, req_addr, req_size, wr_data, wr_data_valid, rd_data_ready,
      input  a_ready, d_opcode, d_param, d_size, d_source, d_sink, d_denied, d_data,
      input  d_corrupt, d_valid,
      output req_ready, wr_data_ready, rd_data, rd_data_valid, rsp_valid, rsp_err,
      output a_opcode, a_param, a_size, a_source, a_address, a_mask, a_data, a_corrupt,
      output a_valid, d_ready
   );

   modport slave (
      output req_valid, req_wr, req_addr, req_size, wr_data, wr_data_valid, rd_data_ready,
      output a_ready, d_opcode, d_param, d_size, d_source, d_sink, d_denied, d_data,
      output d_corrupt, d_valid,
      input  req_ready, wr_data_ready, rd_data, rd_data_valid, rsp_valid, rsp_err,
      input  a_opcode, a_param, a_size, a_source, a_address, a_mask, a_data, a_corrupt,
      input  a_valid, d_ready
   );
endinterface

// File: rtl/tl_line_mst.sv
// rtl/tl_line_mst.sv - TileLink-UH cache-line master (PutFullData burst / Get)
// Bus outputs decode straight from state so they reach the slave in the same cycle.
module tl_line_mst #(
   parameter int SOURCE_ID = 0,
   parameter int MAX_SIZE  = 8
) (
   input  logic          clk,
   input  logic          rst,
   tl_line_mst_if.master bus
);

   typedef enum logic [1:0] {IDLE, A_SEND, D_WAIT, DONE} state_t;

   state_t       r_state;
   logic         r_wr;
   logic [31:0]  r_addr;
   logic [7:0]   r_size;
   logic [4:0]   r_remain;
   logic         r_err;

   logic [7:0]   w_shift;
   logic [4:0]   w_beats;
   logic         w_bad;
   logic         w_a_fire;
   logic         w_d_fire;
   logic         w_d_err;
   logic         w_unused;

   // Shift is only meaningful for legal sizes; illegal ones never use the count.
   assign w_shift  = bus.req_size - 8'd4;
   assign w_beats  = 5'd1 << w_shift[2:0];
   assign w_bad    = (bus.req_size < 8'd4) || (bus.req_size > 8'(MAX_SIZE));
   assign w_a_fire = bus.a_valid & bus.a_ready;
   assign w_d_fire = bus.d_valid & bus.d_ready;
   assign w_d_err  = bus.d_denied | bus.d_corrupt | (bus.d_opcode != (r_wr ? 3'd0 : 3'd1));
   assign w_unused = ^{bus.d_param, bus.d_size, bus.d_source, bus.d_sink, w_shift[7:3]};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state  <= IDLE;
         r_wr     <= 1'b0;
         r_addr   <= 32'd0;
         r_size   <= 8'd0;
         r_remain <= 5'd0;
         r_err    <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (bus.req_valid) begin
                  r_wr     <= bus.req_wr;
                  r_addr   <= bus.req_addr;
                  r_size   <= bus.req_size;
                  r_remain <= w_beats - 5'd1;
                  r_err    <= w_bad;
                  r_state  <= w_bad ? DONE : A_SEND;
               end
            end
            A_SEND: begin
               if (w_a_fire) begin
                  if (!r_wr || r_remain == 5'd0) r_state <= D_WAIT;
                  else                           r_remain <= r_remain - 5'd1;
               end
            end
            D_WAIT: begin
               if (w_d_fire) begin
                  r_err <= r_err | w_d_err;
                  // A write completes on its single ack; a read on its last data beat.
                  if (r_wr || r_remain == 5'd0) r_state <= DONE;
                  else                          r_remain <= r_remain - 5'd1;
               end
            end
            DONE:    r_state <= IDLE;
            default: r_state <= IDLE;
         endcase
      end
   end

   assign bus.req_ready     = (r_state == IDLE);
   assign bus.a_valid       = (r_state == A_SEND) & (r_wr ? bus.wr_data_valid : 1'b1);
   assign bus.wr_data_ready = (r_state == A_SEND) & r_wr & bus.a_ready;
   assign bus.a_opcode      = r_wr ? 3'd0 : 3'd4;
   assign bus.a_param       = 3'd0;
   assign bus.a_size        = r_size;
   assign bus.a_source      = 3'(SOURCE_ID);
   assign bus.a_address     = r_addr;
   assign bus.a_mask        = 16'hFFFF;
   assign bus.a_data        = bus.wr_data;
   assign bus.a_corrupt     = 1'b0;
   assign bus.d_ready       = (r_state == D_WAIT) & (r_wr ? 1'b1 : bus.rd_data_ready);
   assign bus.rd_data_valid = (r_state == D_WAIT) & ~r_wr & bus.d_valid;
   assign bus.rd_data       = bus.d_data;
   assign bus.rsp_valid     = (r_state == DONE);
   assign bus.rsp_err       = (r_state == DONE) & r_err;

endmodule

// File: tb/tb_tl_line_mst.sv
// tb/tb_tl_line_mst.sv - directed self-checking bench for tl_line_mst
// The bench plays both the requester and the TL memory slave.
module tb_tl_line_mst;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_checks = 0;
   int   n_fail   = 0;

   localparam logic [127:0] DA = {32{4'hA}};
   localparam logic [127:0] DB = {32{4'hB}};

   always #5 clk = ~clk;

   tl_line_mst_if bus();

   tl_line_mst #(.SOURCE_ID(0), .MAX_SIZE(8)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   function automatic logic [127:0] pat(input int i);
      return {4{32'hC0DE_0000 + 32'(i)}};
   endfunction

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs;
      bus.req_valid = 0; bus.req_wr = 0; bus.req_addr = 0; bus.req_size = 0;
      bus.wr_data = 0; bus.wr_data_valid = 0; bus.rd_data_ready = 0; bus.a_ready = 0;
      bus.d_opcode = 0; bus.d_param = 0; bus.d_size = 0; bus.d_source = 0; bus.d_sink = 0;
      bus.d_denied = 0; bus.d_data = 0; bus.d_corrupt = 0; bus.d_valid = 0;
   endtask

   task automatic issue_req(input logic wr, input logic [31:0] addr, input logic [7:0] size);
      bus.req_valid = 1; bus.req_wr = wr; bus.req_addr = addr; bus.req_size = size;
      tick;
      bus.req_valid = 0;
   endtask

   task automatic test_reset;
      clear_inputs;
      rst = 1;
      repeat (3) @(posedge clk);
      #1;
      n_checks++;
      if ({bus.a_valid, bus.d_ready, bus.req_ready, bus.wr_data_ready, bus.rd_data_valid,
           bus.rsp_valid, bus.rsp_err} !== 7'b0010000) begin
         n_fail++;
         $display("FAIL reset_outputs: got %b want 0010000", {bus.a_valid, bus.d_ready,
                  bus.req_ready, bus.wr_data_ready, bus.rd_data_valid, bus.rsp_valid, bus.rsp_err});
      end
      rst = 0;
      tick;
   endtask

   task automatic test_write;
      issue_req(1, 32'h8000_0020, 8'd5);
      for (int b = 0; b < 2; b++) begin
         bus.wr_data = (b == 0) ? DA : DB; bus.wr_data_valid = 1; bus.a_ready = 1;
         #1;
         n_checks++;
         if ({bus.a_valid, bus.wr_data_ready, bus.a_opcode, bus.a_address, bus.a_mask, bus.a_size,
              bus.req_ready} !== {1'b1, 1'b1, 3'd0, 32'h8000_0020, 16'hFFFF, 8'd5, 1'b0}) begin
            n_fail++;
            $display("FAIL write_a_fields beat %0d: got v=%b rdy=%b op=%0d addr=%h mask=%h size=%0d req_ready=%b want 1 1 0 80000020 ffff 5 0",
                     b, bus.a_valid, bus.wr_data_ready, bus.a_opcode, bus.a_address, bus.a_mask,
                     bus.a_size, bus.req_ready);
         end
         n_checks++;
         if (bus.a_data !== ((b == 0) ? DA : DB)) begin
            n_fail++;
            $display("FAIL write_a_data beat %0d: got %h want %h", b, bus.a_data, (b == 0) ? DA : DB);
         end
         tick;
      end
      bus.wr_data_valid = 0; bus.a_ready = 0; bus.d_valid = 1; bus.d_opcode = 3'd0;
      #1;
      n_checks++;
      if ({bus.a_valid, bus.d_ready, bus.rsp_valid} !== 3'b010) begin
         n_fail++;
         $display("FAIL write_ack_wait: got %b want 010", {bus.a_valid, bus.d_ready, bus.rsp_valid});
      end
      tick;
      bus.d_valid = 0;
      #1;
      n_checks++;
      if ({bus.rsp_valid, bus.rsp_err, bus.req_ready} !== 3'b100) begin
         n_fail++;
         $display("FAIL write_rsp: got %b want 100", {bus.rsp_valid, bus.rsp_err, bus.req_ready});
      end
      tick;
      n_checks++;
      if ({bus.rsp_valid, bus.req_ready} !== 2'b01) begin
         n_fail++;
         $display("FAIL write_back_idle: got %b want 01", {bus.rsp_valid, bus.req_ready});
      end
   endtask

   task automatic test_read;
      issue_req(0, 32'h8000_0020, 8'd5);
      bus.a_ready = 1;
      #1;
      n_checks++;
      if ({bus.a_valid, bus.a_opcode, bus.a_size, bus.a_address, bus.a_param, bus.a_corrupt,
           bus.a_source} !== {1'b1, 3'd4, 8'd5, 32'h8000_0020, 3'd0, 1'b0, 3'd0}) begin
         n_fail++;
         $display("FAIL read_get_fields: got v=%b op=%0d size=%0d addr=%h param=%0d corrupt=%b src=%0d want 1 4 5 80000020 0 0 0",
                  bus.a_valid, bus.a_opcode, bus.a_size, bus.a_address, bus.a_param,
                  bus.a_corrupt, bus.a_source);
      end
      tick;
      bus.a_ready = 0;
      for (int b = 0; b < 2; b++) begin
         bus.d_valid = 1; bus.d_opcode = 3'd1; bus.d_data = (b == 0) ? DA : DB; bus.rd_data_ready = 1;
         #1;
         n_checks++;
         if ({bus.a_valid, bus.rd_data_valid, bus.d_ready, bus.rsp_valid} !== 4'b0110) begin
            n_fail++;
            $display("FAIL read_beat_ctl %0d: got %b want 0110", b,
                     {bus.a_valid, bus.rd_data_valid, bus.d_ready, bus.rsp_valid});
         end
         n_checks++;
         if (bus.rd_data !== ((b == 0) ? DA : DB)) begin
            n_fail++;
            $display("FAIL read_beat_data %0d: got %h want %h", b, bus.rd_data, (b == 0) ? DA : DB);
         end
         tick;
      end
      bus.d_valid = 0; bus.rd_data_ready = 0;
      #1;
      n_checks++;
      if ({bus.rsp_valid, bus.rsp_err} !== 2'b10) begin
         n_fail++;
         $display("FAIL read_rsp: got %b want 10", {bus.rsp_valid, bus.rsp_err});
      end
      tick;
   endtask

   task automatic test_read_toggle;
      int   idx;
      logic rdr;
      issue_req(0, 32'h0000_1000, 8'd8);
      bus.a_ready = 1;
      tick;
      bus.a_ready = 0;
      idx = 0;
      for (int c = 0; c < 64 && idx < 16; c++) begin
         rdr = (c % 2 == 0);
         bus.rd_data_ready = rdr; bus.d_valid = 1; bus.d_opcode = 3'd1; bus.d_data = pat(idx);
         #1;
         n_checks++;
         if ({bus.d_ready, bus.rd_data_valid, bus.rsp_valid} !== {rdr, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL toggle_ctl cycle %0d: got %b want %b", c,
                     {bus.d_ready, bus.rd_data_valid, bus.rsp_valid}, {rdr, 2'b10});
         end
         if (bus.d_ready && bus.rd_data_valid) begin
            n_checks++;
            if (bus.rd_data !== pat(idx)) begin
               n_fail++;
               $display("FAIL toggle_data beat %0d: got %h want %h", idx, bus.rd_data, pat(idx));
            end
            idx++;
         end
         tick;
      end
      bus.rd_data_ready = 1; bus.d_valid = 1;
      #1;
      n_checks++;
      if (idx != 16 || {bus.rsp_valid, bus.rsp_err, bus.d_ready, bus.rd_data_valid} !== 4'b1000) begin
         n_fail++;
         $display("FAIL toggle_done: got beats=%0d flags=%b want beats=16 flags=1000", idx,
                  {bus.rsp_valid, bus.rsp_err, bus.d_ready, bus.rd_data_valid});
      end
      tick;
      bus.d_valid = 0; bus.rd_data_ready = 0;
   endtask

   task automatic test_write_stall;
      int   idx;
      int   stall;
      logic wv;
      logic ar;
      issue_req(1, 32'h0000_2000, 8'd6);
      idx = 0; stall = 0;
      for (int c = 0; c < 64 && idx < 4; c++) begin
         wv = !(c == 1 || c == 5);
         ar = !(idx == 2 && stall < 3);
         if (idx == 2 && stall < 3) stall++;
         bus.wr_data_valid = wv; bus.a_ready = ar; bus.wr_data = pat(idx + 100);
         #1;
         n_checks++;
         if ({bus.a_valid, bus.wr_data_ready} !== {wv, ar}) begin
            n_fail++;
            $display("FAIL stall_ctl cycle %0d: got %b want %b", c,
                     {bus.a_valid, bus.wr_data_ready}, {wv, ar});
         end
         if (wv) begin
            n_checks++;
            if (bus.a_data !== pat(idx + 100)) begin
               n_fail++;
               $display("FAIL stall_data beat %0d: got %h want %h", idx, bus.a_data, pat(idx + 100));
            end
         end
         if (wv && ar) idx++;
         tick;
      end
      bus.wr_data_valid = 0; bus.a_ready = 1;
      #1;
      n_checks++;
      if (idx != 4 || {bus.a_valid, bus.wr_data_ready, bus.d_ready} !== 3'b001) begin
         n_fail++;
         $display("FAIL stall_end: got beats=%0d flags=%b want beats=4 flags=001", idx,
                  {bus.a_valid, bus.wr_data_ready, bus.d_ready});
      end
      bus.d_valid = 1; bus.d_opcode = 3'd0;
      tick;
      bus.d_valid = 0; bus.a_ready = 0;
      #1;
      n_checks++;
      if ({bus.rsp_valid, bus.rsp_err} !== 2'b10) begin
         n_fail++;
         $display("FAIL stall_rsp: got %b want 10", {bus.rsp_valid, bus.rsp_err});
      end
      tick;
   endtask

   task automatic test_illegal_size;
      logic [7:0] sz;
      for (int i = 0; i < 2; i++) begin
         sz = (i == 0) ? 8'd3 : 8'd9;
         bus.a_ready = 1;
         issue_req(0, 32'h0000_3000, sz);
         #1;
         n_checks++;
         if ({bus.a_valid, bus.rsp_valid, bus.rsp_err, bus.req_ready} !== 4'b0110) begin
            n_fail++;
            $display("FAIL illegal_rsp size %0d: got %b want 0110", sz,
                     {bus.a_valid, bus.rsp_valid, bus.rsp_err, bus.req_ready});
         end
         tick;
         n_checks++;
         if ({bus.a_valid, bus.rsp_valid, bus.req_ready} !== 3'b001) begin
            n_fail++;
            $display("FAIL illegal_idle size %0d: got %b want 001", sz,
                     {bus.a_valid, bus.rsp_valid, bus.req_ready});
         end
      end
      bus.a_ready = 0;
   endtask

   task automatic test_denied_and_reset;
      issue_req(0, 32'h0000_4000, 8'd5);
      bus.a_ready = 1;
      tick;
      bus.a_ready = 0;
      for (int b = 0; b < 2; b++) begin
         bus.d_valid = 1; bus.d_opcode = 3'd1; bus.d_denied = (b == 0);
         bus.d_data = pat(b + 200); bus.rd_data_ready = 1;
         #1;
         n_checks++;
         if ({bus.rd_data_valid, bus.d_ready} !== 2'b11 || bus.rd_data !== pat(b + 200)) begin
            n_fail++;
            $display("FAIL denied_beat %0d: got flags=%b data=%h want flags=11 data=%h", b,
                     {bus.rd_data_valid, bus.d_ready}, bus.rd_data, pat(b + 200));
         end
         tick;
      end
      bus.d_valid = 0; bus.d_denied = 0;
      #1;
      n_checks++;
      if ({bus.rsp_valid, bus.rsp_err} !== 2'b11) begin
         n_fail++;
         $display("FAIL denied_rsp: got %b want 11", {bus.rsp_valid, bus.rsp_err});
      end
      tick;

      issue_req(0, 32'h0000_5000, 8'd8);
      bus.a_ready = 1;
      tick;
      bus.a_ready = 0;
      bus.d_valid = 1; bus.d_opcode = 3'd1; bus.rd_data_ready = 1; bus.d_data = pat(300);
      repeat (3) tick;
      n_checks++;
      if ({bus.rd_data_valid, bus.d_ready} !== 2'b11) begin
         n_fail++;
         $display("FAIL midread_active: got %b want 11", {bus.rd_data_valid, bus.d_ready});
      end
      rst = 1;
      tick;
      n_checks++;
      if ({bus.a_valid, bus.d_ready, bus.req_ready, bus.wr_data_ready, bus.rd_data_valid,
           bus.rsp_valid, bus.rsp_err} !== 7'b0010000) begin
         n_fail++;
         $display("FAIL midread_reset: got %b want 0010000", {bus.a_valid, bus.d_ready,
                  bus.req_ready, bus.wr_data_ready, bus.rd_data_valid, bus.rsp_valid, bus.rsp_err});
      end
      rst = 0;
      clear_inputs;
      tick;
   endtask

   initial begin
      test_reset;
      test_write;
      test_read;
      test_read_toggle;
      test_write_stall;
      test_illegal_size;
      test_denied_and_reset;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got no end of test by 200000 want end of test");
      $fatal(1, "timeout");
   end

endmodule
